// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Purpose  : Round-robin arbiter sharing one SPI master between two requesters.
// Revision : 1.0
// ============================================================================
module spi_arbiter #(
  parameter int DATA    = 8,
  parameter int ADDR    = 3,
  parameter int TIMEOUT = 32
) (
  input  logic            clk,
  input  logic            presetn,
  input  logic            req0,
  input  logic            req1,
  input  logic [DATA-1:0] wdata0,
  input  logic [DATA-1:0] wdata1,
  input  logic [ADDR-1:0] cfg0,
  input  logic [ADDR-1:0] cfg1,
  input  logic            txc,
  input  logic [DATA-1:0] m_rdata,
  output logic            spe,
  output logic            m_wr_rdbar,
  output logic [ADDR-1:0] m_addr,
  output logic [DATA-1:0] m_wdata,
  output logic            gnt0,
  output logic            gnt1,
  output logic            done0,
  output logic            done1,
  output logic [DATA-1:0] rdata0,
  output logic [DATA-1:0] rdata1,
  output logic            err,
  output logic            busy
);

  localparam int              CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [1:0]      S_IDLE  = 2'd0;
  localparam logic [1:0]      S_XFER  = 2'd1;
  localparam logic [1:0]      S_DONE  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            last_q, last_d;
  logic            spe_q, spe_d;
  logic            wr_q, wr_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [DATA-1:0] wdata_q, wdata_d;
  logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic            done0_q, done0_d, done1_q, done1_d;
  logic [DATA-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic            err_q, err_d;
  logic            pick;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick = req1 & (~req0 | ~last_q);

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      spe_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      spe_q    <= spe_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!txc && (req0 || req1)) state_d = S_XFER;
      S_XFER:  if (txc || (cnt_q == CNT_MAX)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    last_d   = last_q;
    spe_d    = spe_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = done0_q;
    done1_d  = done1_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_XFER) begin
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          wdata_d = pick ? wdata1 : wdata0;
          addr_d  = pick ? cfg1 : cfg0;
          spe_d   = 1'b1;
          wr_d    = 1'b1;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_XFER: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
        if (state_d == S_DONE) begin
          spe_d   = 1'b0;
          wr_d    = 1'b0;
          done0_d = gnt0_q;
          done1_d = gnt1_q;
          // A completion seen on the timeout cycle still counts as success.
          err_d   = ~txc;
          if (txc && gnt0_q) rdata0_d = m_rdata;
          if (txc && gnt1_q) rdata1_d = m_rdata;
        end
      end
      S_DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        last_d  = gnt1_q;
      end
      default: begin
        spe_d = 1'b0;
        wr_d  = 1'b0;
      end
    endcase
  end

  assign spe        = spe_q;
  assign m_wr_rdbar = wr_q;
  assign m_addr     = addr_q;
  assign m_wdata    = wdata_q;
  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign done0      = done0_q;
  assign done1      = done1_q;
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Purpose  : Scenario bench for spi_arbiter with an expected-transfer queue.
// Revision : 1.0
// ============================================================================
module tb_spi_arbiter;

  logic       clk = 1'b0;
  logic       presetn;
  logic       req0, req1, txc;
  logic [7:0] wdata0, wdata1, m_rdata;
  logic [2:0] cfg0, cfg1;
  logic       spe, m_wr_rdbar, gnt0, gnt1, done0, done1, err, busy;
  logic [2:0] m_addr;
  logic [7:0] m_wdata, rdata0, rdata1;

  typedef struct {
    logic       who;
    logic       err;
    logic [7:0] rd;
    logic [7:0] wd;
    logic [2:0] ad;
    int         ncyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_rd[2];
  int         vec  = 0;
  int         miss = 0;

  spi_arbiter #(.DATA(8), .ADDR(3), .TIMEOUT(32)) dut (
    .clk(clk), .presetn(presetn), .req0(req0), .req1(req1),
    .wdata0(wdata0), .wdata1(wdata1), .cfg0(cfg0), .cfg1(cfg1),
    .txc(txc), .m_rdata(m_rdata), .spe(spe), .m_wr_rdbar(m_wr_rdbar),
    .m_addr(m_addr), .m_wdata(m_wdata), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    presetn = 1'b0;
    req0 = 0; req1 = 0; txc = 0; m_rdata = 8'h00;
    wdata0 = 8'h00; wdata1 = 8'h00; cfg0 = 3'd0; cfg1 = 3'd0;
    model_rd[0] = 8'h00; model_rd[1] = 8'h00;
    repeat (2) @(negedge clk);
    presetn = 1'b1;
    @(negedge clk);
  endtask

  // Runs one transfer from an idle/done negedge; requester inputs are
  // scrambled after the first XFER cycle so held command fields are exercised.
  task automatic serve(input int txc_at, input logic [7:0] rx, input bit hold_txc,
                       output int ncyc, output logic [24:0] obs);
    logic g0, g1, wr;
    logic [7:0] wd;
    logic [2:0] ad;
    int k;
    ncyc = -1;
    obs  = 'x;
    wd   = 'x;
    ad   = 'x;
    m_rdata = 8'hEE;
    k = 0;
    while (spe !== 1'b1 && k < 6) begin @(negedge clk); k++; end
    if (spe !== 1'b1) return;
    g0 = gnt0; g1 = gnt1; wr = m_wr_rdbar;
    ncyc = 0;
    k = 0;
    while (spe === 1'b1 && k < 200) begin
      ncyc++;
      wd = m_wdata; ad = m_addr;
      if (ncyc == 1) begin
        wdata0 = ~wdata0; wdata1 = ~wdata1; cfg0 = ~cfg0; cfg1 = ~cfg1;
      end
      if (ncyc == txc_at) begin txc = 1'b1; m_rdata = rx; end
      @(negedge clk);
      k++;
    end
    if (spe === 1'b1) begin ncyc = -1; return; end
    obs = {g0, g1, wr, done0, done1, err, wd, ad, (g1 ? rdata1 : rdata0)};
    if (!hold_txc) txc = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] snap;
    presetn = 1'b0;
    req0 = 1; req1 = 1; txc = 0;
    #3;
    snap = {spe, m_wr_rdbar, m_addr, m_wdata, gnt0, gnt1, done0, done1, rdata0, rdata1, err, busy};
    vec++;
    if (snap !== '0) begin miss++; $display("FAIL reset_outputs: got %h required 0", snap); end
    do_reset();
    repeat (2) @(negedge clk);
    vec++;
    if ({busy, spe, gnt0, gnt1} !== 4'b0000)
      begin miss++; $display("FAIL idle_no_req: busy/spe/gnt got %b required 0000", {busy, spe, gnt0, gnt1}); end
  endtask

  task automatic test_single();
    exp_t e;
    int n;
    logic [24:0] obs;
    wdata0 = 8'hA5; cfg0 = 3'b001; req0 = 1'b1;
    model_rd[0] = 8'h3C;
    sb.push_back('{who: 1'b0, err: 1'b0, rd: 8'h3C, wd: 8'hA5, ad: 3'b001, ncyc: 10});
    serve(10, 8'h3C, 1'b0, n, obs);
    req0 = 1'b0;
    e = sb.pop_front();
    vec++;
    if (n != e.ncyc) begin miss++; $display("FAIL single_spe_cycles: got %0d required %0d", n, e.ncyc); end
    vec++;
    if (obs !== {~e.who, e.who, 1'b1, ~e.who, e.who, e.err, e.wd, e.ad, e.rd})
      begin miss++; $display("FAIL single_xfer: got %h required %h", obs, {~e.who, e.who, 1'b1, ~e.who, e.who, e.err, e.wd, e.ad, e.rd}); end
    @(negedge clk);
    vec++;
    if ({done0, done1, gnt0, gnt1, busy} !== 5'b00000)
      begin miss++; $display("FAIL single_done_pulse: done/gnt/busy got %b required 00000", {done0, done1, gnt0, gnt1, busy}); end
  endtask

  task automatic test_tie();
    exp_t e;
    int n;
    logic [24:0] obs;
    logic w;
    do_reset();
    for (int t = 0; t < 3; t++) begin
      w = (t == 1);
      req0 = !w; req1 = 1'b1;
      wdata0 = 8'h10 + 8'(t); wdata1 = 8'h20 + 8'(t);
      cfg0 = 3'(t); cfg1 = 3'(t + 4);
      model_rd[w] = 8'h50 + 8'(t);
      sb.push_back('{who: w, err: 1'b0, rd: 8'h50 + 8'(t), wd: w ? wdata1 : wdata0,
                     ad: w ? cfg1 : cfg0, ncyc: 2});
      serve(2, 8'h50 + 8'(t), 1'b0, n, obs);
      e = sb.pop_front();
      vec++;
      if (n != e.ncyc || obs !== {~e.who, e.who, 1'b1, ~e.who, e.who, e.err, e.wd, e.ad, e.rd})
        begin miss++; $display("FAIL tie_round%0d: got n=%0d %h required n=%0d %h", t, n, obs, e.ncyc,
                               {~e.who, e.who, 1'b1, ~e.who, e.who, e.err, e.wd, e.ad, e.rd}); end
      @(negedge clk);
      vec++;
      if ({done0, done1, gnt0, gnt1} !== 4'b0000)
        begin miss++; $display("FAIL tie_done_pulse%0d: got %b required 0000", t, {done0, done1, gnt0, gnt1}); end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    exp_t e;
    int n;
    logic [24:0] obs;
    req1 = 1'b1; wdata1 = 8'h77; cfg1 = 3'b110;
    sb.push_back('{who: 1'b1, err: 1'b1, rd: model_rd[1], wd: 8'h77, ad: 3'b110, ncyc: 32});
    serve(0, 8'h00, 1'b0, n, obs);
    req1 = 1'b0;
    e = sb.pop_front();
    vec++;
    if (n != e.ncyc) begin miss++; $display("FAIL timeout_cycles: got %0d required %0d", n, e.ncyc); end
    vec++;
    if (obs !== {~e.who, e.who, 1'b1, ~e.who, e.who, e.err, e.wd, e.ad, e.rd})
      begin miss++; $display("FAIL timeout_xfer: got %h required %h", obs, {~e.who, e.who, 1'b1, ~e.who, e.who, e.err, e.wd, e.ad, e.rd}); end
    @(negedge clk);
    vec++;
    if ({done1, gnt1, err} !== 3'b001)
      begin miss++; $display("FAIL timeout_err_held: done1/gnt1/err got %b required 001", {done1, gnt1, err}); end
  endtask

  task automatic test_txc_hold();
    exp_t e;
    int n;
    logic [24:0] obs;
    logic seen;
    req0 = 1'b1; wdata0 = 8'h3A; cfg0 = 3'b010;
    model_rd[0] = 8'h99;
    sb.push_back('{who: 1'b0, err: 1'b0, rd: 8'h99, wd: 8'h3A, ad: 3'b010, ncyc: 3});
    serve(3, 8'h99, 1'b1, n, obs);
    e = sb.pop_front();
    vec++;
    if (n != e.ncyc || obs !== {~e.who, e.who, 1'b1, ~e.who, e.who, e.err, e.wd, e.ad, e.rd})
      begin miss++; $display("FAIL hold_first_xfer: got n=%0d %h required n=%0d %h", n, obs, e.ncyc,
                             {~e.who, e.who, 1'b1, ~e.who, e.who, e.err, e.wd, e.ad, e.rd}); end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || spe !== 1'b0) seen = 1'b1;
    end
    vec++;
    if (seen !== 1'b0) begin miss++; $display("FAIL hold_no_grant: grant seen=%b required 0", seen); end
    txc = 1'b0;
    wdata0 = 8'h5B;
    @(negedge clk);
    vec++;
    if ({gnt0, spe, m_wdata} !== {2'b11, 8'h5B})
      begin miss++; $display("FAIL hold_regrant: got %h required %h", {gnt0, spe, m_wdata}, {2'b11, 8'h5B}); end
    txc = 1'b1; m_rdata = 8'h42; req0 = 1'b0;
    model_rd[0] = 8'h42;
    @(negedge clk);
    txc = 1'b0;
    vec++;
    if ({done0, err, rdata0} !== {2'b10, model_rd[0]})
      begin miss++; $display("FAIL hold_second_done: got %h required %h", {done0, err, rdata0}, {2'b10, model_rd[0]}); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic seen;
    int k;
    req1 = 1'b1; txc = 1'b0; wdata1 = 8'hC3; cfg1 = 3'b101;
    k = 0;
    while (spe !== 1'b1 && k < 6) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    vec++;
    if ({spe, gnt1, busy} !== 3'b111)
      begin miss++; $display("FAIL rst_mid_active: spe/gnt1/busy got %b required 111", {spe, gnt1, busy}); end
    #2 presetn = 1'b0;
    #1;
    vec++;
    if ({spe, gnt0, gnt1, busy, done0, done1} !== 6'b000000)
      begin miss++; $display("FAIL rst_mid_async: got %b required 000000", {spe, gnt0, gnt1, busy, done0, done1}); end
    model_rd[0] = 8'h00; model_rd[1] = 8'h00;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done0 !== 1'b0 || done1 !== 1'b0) seen = 1'b1;
    end
    presetn = 1'b1;
    @(negedge clk);
    if (done0 !== 1'b0 || done1 !== 1'b0) seen = 1'b1;
    vec++;
    if (seen !== 1'b0) begin miss++; $display("FAIL rst_mid_no_done: done seen=%b required 0", seen); end
    vec++;
    if ({gnt1, gnt0, spe, m_wdata, m_addr} !== {3'b101, 8'hC3, 3'b101})
      begin miss++; $display("FAIL rst_mid_regrant: got %h required %h", {gnt1, gnt0, spe, m_wdata, m_addr}, {3'b101, 8'hC3, 3'b101}); end
    txc = 1'b1; m_rdata = 8'h1E; req1 = 1'b0;
    model_rd[1] = 8'h1E;
    @(negedge clk);
    txc = 1'b0;
    vec++;
    if ({done1, done0, err, rdata1, rdata0} !== {3'b100, model_rd[1], model_rd[0]})
      begin miss++; $display("FAIL rst_mid_done: got %h required %h", {done1, done0, err, rdata1, rdata0},
                             {3'b100, model_rd[1], model_rd[0]}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_timeout();
    test_txc_hold();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
`default_nettype wire
